// File: rtl/store_write_buffer_pkg.sv
// Shared types for the posted-store write buffer: store sizes, the buffered
// entry layout and the drain FSM encoding.
package wb_pkg;

    localparam int WB_WIDTH = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_t;

    typedef struct packed {
        logic [WB_WIDTH-1:0] addr;
        logic [WB_WIDTH-1:0] data;
        size_t               size;
    } entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Occupancy counter must hold 0..depth inclusive.
    function automatic int count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/store_write_buffer_cam.sv
// Entry storage for the write buffer with per-entry valid bits and a parallel
// word-address compare used to detect loads hitting a pending store.
module write_buffer_cam
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_wr_en,
    input  logic [PTR_W-1:0]      i_wr_ptr,
    input  entry_t                i_wr_entry,
    input  logic                  i_rd_en,
    input  logic [PTR_W-1:0]      i_rd_ptr,
    output entry_t                o_head,
    input  logic [WB_WIDTH-3:0]   i_ld_word,
    output logic                  o_match
);

    entry_t             r_mem [DEPTH];
    logic [DEPTH-1:0]   r_valid;
    logic               w_hit;

    // A push never lands on the head slot while it is live, so clear-then-set
    // ordering is only a formality here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_valid <= '0;
        end else begin
            if (i_rd_en) begin
                r_valid[i_rd_ptr] <= 1'b0;
            end
            if (i_wr_en) begin
                r_mem[i_wr_ptr]   <= i_wr_entry;
                r_valid[i_wr_ptr] <= 1'b1;
            end
        end
    end

    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_mem[i].addr[WB_WIDTH-1:2] == i_ld_word)) begin
                w_hit = 1'b1;
            end
        end
    end

    assign o_head  = r_mem[i_rd_ptr];
    assign o_match = w_hit;

endmodule

// File: rtl/store_write_buffer.sv
// Posted-store FIFO between the memory stage and RAM: pointers, occupancy,
// drain handshake and memory-stage stall generation.
//
// state | meaning
// IDLE  | nothing to drain, ram_wen low
// BUSY  | head entry presented to RAM, waiting for ram_ack
module store_write_buffer
    import wb_pkg::*;
#(
    parameter int WIDTH = WB_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    st_valid,
    input  logic [1:0]              st_size,
    input  logic [WIDTH-1:0]        st_addr,
    input  logic [WIDTH-1:0]        st_data,
    output logic                    st_ready,
    input  logic                    ld_valid,
    input  logic [WIDTH-1:0]        ld_addr,
    output logic                    ld_conflict,
    output logic                    stall,
    output logic                    ram_wen,
    output logic [1:0]              ram_size,
    output logic [WIDTH-1:0]        ram_addr,
    output logic [WIDTH-1:0]        ram_wdata,
    input  logic                    ram_ack,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int COUNT_W = count_w(DEPTH);

    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [COUNT_W-1:0] r_count;
    logic [COUNT_W-1:0] w_count_nxt;
    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_push;
    logic               w_pop;
    logic               w_match;
    logic               w_busy;
    entry_t             w_wr_entry;
    entry_t             w_head;
    logic               w_unused_ld_lsb;

    assign st_ready    = (r_count != COUNT_W'(DEPTH));
    assign w_push      = st_valid && st_ready;
    assign w_pop       = w_busy && ram_ack;
    assign w_count_nxt = r_count + COUNT_W'(w_push) - COUNT_W'(w_pop);

    always_comb begin
        w_wr_entry      = '0;
        w_wr_entry.addr = st_addr;
        w_wr_entry.data = st_data;
        w_wr_entry.size = size_t'(st_size);
    end

    write_buffer_cam #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_cam (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wr_en    (w_push),
        .i_wr_ptr   (r_wr_ptr),
        .i_wr_entry (w_wr_entry),
        .i_rd_en    (w_pop),
        .i_rd_ptr   (r_rd_ptr),
        .o_head     (w_head),
        .i_ld_word  (ld_addr[WIDTH-1:2]),
        .o_match    (w_match)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_count_nxt != '0) w_state_nxt = BUSY;
            BUSY: if (w_pop && (w_count_nxt == '0)) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_busy  = 1'b0;
        ram_wen = 1'b0;
        case (r_state)
            BUSY: begin
                w_busy  = 1'b1;
                ram_wen = 1'b1;
            end
            default: begin
                w_busy  = 1'b0;
                ram_wen = 1'b0;
            end
        endcase
    end

    assign ram_size        = w_head.size;
    assign ram_addr        = w_head.addr;
    assign ram_wdata       = w_head.data;
    assign ld_conflict     = ld_valid && w_match;
    assign stall           = (st_valid && !st_ready) || ld_conflict;
    assign empty           = (r_count == '0);
    assign count           = r_count;
    assign w_unused_ld_lsb = &{1'b0, ld_addr[1:0]};

    a_ld_st_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(st_valid && ld_valid));
    a_st_size_legal: assert property (@(posedge clk) disable iff (!rst_n)
        !(st_valid && (st_size == 2'b11)));

endmodule

// File: doc/store_write_buffer.md
# store_write_buffer

Posted-store FIFO between the memory stage and main RAM. The memory stage uses a write-through cache: every sw/sh/sb updates the cache in the same cycle, and the RAM copy is deferred into this buffer. The buffer drains to RAM over a valid/ack handshake and tells the memory stage when it must stall. A stall is needed when the buffer is full, or when a load targets a word that still has a store waiting here.

## Interface
Parameters:
- WIDTH, 32, data and address width.
- DEPTH, 4, number of entries; a power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- st_valid  in  1  a store is offered this cycle (sw|sh|sb).
- st_size  in  2  store size: 00 byte, 01 half, 10 word; 11 is illegal.
- st_addr  in  WIDTH  store byte address (the ALU result).
- st_data  in  WIDTH  store data, unshifted (the register value).
- st_ready  out  1  buffer can accept a store this cycle.
- ld_valid  in  1  a load is in the memory stage this cycle.
- ld_addr  in  WIDTH  load byte address.
- ld_conflict  out  1  a live entry matches the load's word.
- stall  out  1  memory stage must hold this cycle.
- ram_wen  out  1  write request to RAM.
- ram_size  out  2  size of the head entry.
- ram_addr  out  WIDTH  address of the head entry.
- ram_wdata  out  WIDTH  data of the head entry.
- ram_ack  in  1  RAM accepts the head write at this edge.
- empty  out  1  no live entries.
- count  out  $clog2(DEPTH)+1  number of live entries.

## Operation
- Circular FIFO:
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
  - count is a separate register, 0..DEPTH.
- Push: st_valid && st_ready. The entry {addr, data, size} is written at wr_ptr and wr_ptr increments.
- st_ready = (count != DEPTH). It depends only on registered state; there is no combinational pass-through when a pop happens in the same cycle.
- A store offered while full (st_valid && !st_ready) is not written. The memory stage holds it via stall.
- Drain FSM, two states:
  - IDLE: ram_wen=0. Go to BUSY at the edge where the next count is non-zero.
  - BUSY: ram_wen=1 and the head entry drives ram_size/addr/wdata.
  - In BUSY, on ram_ack: pop (rd_ptr increments). Stay in BUSY if the post-edge count is non-zero, otherwise go to IDLE.
- ram_* outputs are held stable while ram_wen=1 and ram_ack=0.
- Simultaneous push and pop: count unchanged and both pointers advance.
- ld_conflict:
  - Asserted when ld_valid is high and ld_addr[WIDTH-1:2] equals the entry addr[WIDTH-1:2] of any live entry, including the head currently on the RAM port.
  - Comparison is at word granularity regardless of size; a conservative match is accepted.
  - It is combinational on registered state.
- stall = (st_valid && !st_ready) || ld_conflict.
- st_valid and ld_valid are mutually exclusive. This is covered by an assertion; behaviour is undefined if both are high.
- ram_ack while ram_wen=0 is ignored.
- st_size=11 is covered by an assertion.

## Timing
- Reset values (applied immediately on the rst_n falling edge, asynchronously):
  - st_ready=1, empty=1, count=0, ld_conflict=0, stall=0, ram_wen=0.
  - ram_size=0, ram_addr=0, ram_wdata=0; all entry storage is cleared.
  - Both pointers 0, FSM in IDLE.
- Reset mid-drain: all pending stores are discarded and the RAM request drops in the same cycle.
- Push-to-request latency: a store pushed at edge N into an empty buffer has ram_wen=1 during cycle N+1.
- Throughput: with ram_ack held high, one entry drains per cycle and ram_wen stays high continuously.
- ld_conflict clears in the cycle after the ack edge of the last matching entry.
- A load stalled on a conflict therefore waits at least one cycle per matching entry ahead of it.

## Structure
- Package wb_pkg holds:
  - size_t enum: SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - entry_t struct: addr, data, size.
  - state_t enum: IDLE, BUSY.
  - a COUNT_W localparam function.
- Sub-module write_buffer_cam holds:
  - the DEPTH-entry storage and per-entry valid bits;
  - the parallel word-address compare producing a match bit.
- The top level holds the pointers, count, drain FSM and stall logic.

## Test plan
- Single store: push {sw, 0x100, 0xDEADBEEF}, ram_ack high the next cycle.
  - ram_wen high exactly one cycle, carrying addr 0x100, data 0xDEADBEEF, size 10.
  - empty=1 afterwards.
- Fill and overflow: 4 pushes with ram_ack=0, then a 5th push.
  - After the 4th push, count=4 and st_ready=0.
  - During the 5th push, stall=1 and count stays 4.
  - Raise ram_ack: entries drain in FIFO order, one per cycle.
- Load hazard: pending sb to 0x203, then ld_addr=0x200.
  - ld_conflict=1 until the ack edge for that entry.
  - ld_addr=0x204 gives ld_conflict=0.
- Simultaneous push and pop at count=2: count stays 2 and the pointers wrap correctly past DEPTH-1.
- Backpressure hold: ram_ack low for 5 cycles; ram_addr, ram_wdata and ram_size stay constant throughout.
- Reset mid-drain: pull rst_n low with 3 entries pending.
  - ram_wen=0, count=0 and st_ready=1 immediately, without waiting for a clock edge.
  - No write reaches RAM after reset.
